// File: rtl/cache_level_sim_if.sv
// Request/response handshake between a requester and one cache level.
// The master drives requests; the slave (cache level) answers.
interface cache_level_sim_if #(
    parameter int ADDR_W = 48
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic              resp_valid;
    logic              resp_hit;

    modport master (
        output req_valid, req_write, req_addr,
        input  req_ready, resp_valid, resp_hit
    );

    modport slave (
        input  req_valid, req_write, req_addr,
        output req_ready, resp_valid, resp_hit
    );
endinterface

// File: rtl/cache_level_sim.sv
// Single parametrised cache level: set-assoc lookup, FIFO/LRU replacement, stats.
// Define CACHE_LVL_STAT_SAT_EN to make the statistics counters saturate.
module cache_level_sim #(
    parameter int ADDR_W   = 48,
    parameter int OFF_W    = 6,
    parameter int NUM_SETS = 64,
    parameter int ASSOC    = 4,
    parameter int REPL_LRU = 1,
    parameter int CNT_W    = 18
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              write_policy_i,
    cache_level_sim_if.slave  req,
    output logic              evict_valid_o,
    output logic [ADDR_W-1:0] evict_addr_o,
    output logic              wt_valid_o,
    output logic [ADDR_W-1:0] wt_addr_o,
    output logic [CNT_W-1:0]  reads_o,
    output logic [CNT_W-1:0]  writes_o,
    output logic [CNT_W-1:0]  read_misses_o,
    output logic [CNT_W-1:0]  write_misses_o,
    output logic [CNT_W-1:0]  writebacks_o
);
    localparam int IDX_W = $clog2(NUM_SETS);
    localparam int TAG_W = ADDR_W - OFF_W - IDX_W;
    localparam int WAY_W = (ASSOC > 1) ? $clog2(ASSOC) : 1;
    localparam logic [WAY_W-1:0] LAST_WAY = WAY_W'(ASSOC - 1);

    typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_UPDATE} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              wr_q, wr_d;
    logic              pol_q, pol_d;
    logic              hit_q, hit_d;
    logic [WAY_W-1:0]  way_q, way_d;
    logic [CNT_W-1:0]  reads_q, reads_d;
    logic [CNT_W-1:0]  writes_q, writes_d;
    logic [CNT_W-1:0]  rmiss_q, rmiss_d;
    logic [CNT_W-1:0]  wmiss_q, wmiss_d;
    logic [CNT_W-1:0]  wb_q, wb_d;

    logic             valid_q [NUM_SETS][ASSOC];
    logic             dirty_q [NUM_SETS][ASSOC];
    logic [TAG_W-1:0] tag_q   [NUM_SETS][ASSOC];
    logic [WAY_W-1:0] age_q   [NUM_SETS][ASSOC];
    logic [WAY_W-1:0] fifo_q  [NUM_SETS];

    logic             valid_row_d [ASSOC];
    logic             dirty_row_d [ASSOC];
    logic [WAY_W-1:0] age_row_d   [ASSOC];
    logic [WAY_W-1:0] fifo_d;

    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag;

    assign idx = addr_q[OFF_W +: IDX_W];
    assign tag = addr_q[ADDR_W-1 -: TAG_W];

    function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] c);
`ifdef CACHE_LVL_STAT_SAT_EN
        return (&c) ? c : c + 1'b1;
`else
        return c + 1'b1;
`endif
    endfunction

    logic             lk_hit, inv_found;
    logic [WAY_W-1:0] lk_way, inv_way, old_way, old_age, victim;

    always_comb begin
        lk_hit    = 1'b0;
        lk_way    = '0;
        inv_found = 1'b0;
        inv_way   = '0;
        old_way   = '0;
        old_age   = '0;
        for (int w = 0; w < ASSOC; w++) begin
            if (valid_q[idx][w] && tag_q[idx][w] == tag && !lk_hit) begin
                lk_hit = 1'b1;
                lk_way = WAY_W'(w);
            end
            if (!valid_q[idx][w] && !inv_found) begin
                inv_found = 1'b1;
                inv_way   = WAY_W'(w);
            end
            if (age_q[idx][w] > old_age) begin
                old_age = age_q[idx][w];
                old_way = WAY_W'(w);
            end
        end
        if (inv_found) victim = inv_way;
        else if (REPL_LRU != 0) victim = old_way;
        else victim = fifo_q[idx];
    end

    logic             upd, fill, touch, vic_valid, vic_dirty, evict;
    logic [WAY_W-1:0] ref_age;

    assign upd       = (state_q == S_UPDATE) && !reset_i;
    assign fill      = !hit_q && (!wr_q || pol_q);
    assign touch     = hit_q || fill;
    assign vic_valid = valid_q[idx][way_q];
    assign vic_dirty = dirty_q[idx][way_q];
    assign evict     = fill && vic_valid && vic_dirty;
    // Filling an empty way ages every other way as if the newcomer were oldest.
    assign ref_age   = vic_valid ? age_q[idx][way_q] : LAST_WAY;

    always_comb begin
        for (int w = 0; w < ASSOC; w++) begin
            valid_row_d[w] = valid_q[idx][w];
            dirty_row_d[w] = dirty_q[idx][w];
            age_row_d[w]   = age_q[idx][w];
            if (touch) begin
                if (WAY_W'(w) == way_q) age_row_d[w] = '0;
                else if (age_q[idx][w] < ref_age) age_row_d[w] = age_q[idx][w] + 1'b1;
            end
        end
        fifo_d = fifo_q[idx];
        if (fill) begin
            valid_row_d[way_q] = 1'b1;
            dirty_row_d[way_q] = wr_q;
            fifo_d = (fifo_q[idx] == LAST_WAY) ? '0 : fifo_q[idx] + 1'b1;
        end else if (hit_q && wr_q && pol_q) begin
            dirty_row_d[way_q] = 1'b1;
        end
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        wr_d     = wr_q;
        pol_d    = pol_q;
        hit_d    = hit_q;
        way_d    = way_q;
        reads_d  = reads_q;
        writes_d = writes_q;
        rmiss_d  = rmiss_q;
        wmiss_d  = wmiss_q;
        wb_d     = wb_q;
        unique case (state_q)
            S_IDLE: begin
                if (req.req_valid) begin
                    addr_d  = req.req_addr;
                    wr_d    = req.req_write;
                    pol_d   = write_policy_i;
                    state_d = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                hit_d   = lk_hit;
                way_d   = lk_hit ? lk_way : victim;
                state_d = S_UPDATE;
            end
            S_UPDATE: begin
                state_d = S_IDLE;
                if (wr_q) writes_d = bump(writes_q);
                else reads_d = bump(reads_q);
                if (wr_q && !hit_q) wmiss_d = bump(wmiss_q);
                if (!wr_q && !hit_q) rmiss_d = bump(rmiss_q);
                if (evict) wb_d = bump(wb_q);
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            wr_q     <= 1'b0;
            pol_q    <= 1'b0;
            hit_q    <= 1'b0;
            way_q    <= '0;
            reads_q  <= '0;
            writes_q <= '0;
            rmiss_q  <= '0;
            wmiss_q  <= '0;
            wb_q     <= '0;
            for (int s = 0; s < NUM_SETS; s++) begin
                fifo_q[s] <= '0;
                for (int w = 0; w < ASSOC; w++) begin
                    valid_q[s][w] <= 1'b0;
                    dirty_q[s][w] <= 1'b0;
                    age_q[s][w]   <= '0;
                end
            end
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wr_q     <= wr_d;
            pol_q    <= pol_d;
            hit_q    <= hit_d;
            way_q    <= way_d;
            reads_q  <= reads_d;
            writes_q <= writes_d;
            rmiss_q  <= rmiss_d;
            wmiss_q  <= wmiss_d;
            wb_q     <= wb_d;
            if (upd) begin
                fifo_q[idx] <= fifo_d;
                for (int w = 0; w < ASSOC; w++) begin
                    valid_q[idx][w] <= valid_row_d[w];
                    dirty_q[idx][w] <= dirty_row_d[w];
                    age_q[idx][w]   <= age_row_d[w];
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (state_q == S_UPDATE && fill) tag_q[idx][way_q] <= tag;
    end

    assign req.req_ready  = (state_q == S_IDLE) && !reset_i;
    assign req.resp_valid = upd;
    assign req.resp_hit   = upd && hit_q;
    assign evict_valid_o  = upd && evict;
    assign evict_addr_o   = {tag_q[idx][way_q], idx, {OFF_W{1'b0}}};
    assign wt_valid_o     = upd && wr_q && !pol_q;
    assign wt_addr_o      = addr_q;
    assign reads_o        = reads_q;
    assign writes_o       = writes_q;
    assign read_misses_o  = rmiss_q;
    assign write_misses_o = wmiss_q;
    assign writebacks_o   = wb_q;
endmodule
